// File: rtl/mips_cache_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mips_cache_pkg
//  Description : Shared definitions for the MIPS data-cache miss/store
//                controller: controller state encoding, default memory
//                timeout and bus widths.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package mips_cache_pkg;

   localparam int WORD_W          = 32;
   localparam int BE_W            = WORD_W / 8;
   localparam int TIMEOUT_DEFAULT = 255;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_FILL = 3'd2,
      ST_WR_REQ  = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

endpackage
`default_nettype wire

// File: rtl/mips_cache_controller_if.sv
`default_nettype none
// ============================================================================
//  Interface   : mips_cache_controller_if
//  Description : Bundles the CPU strobes, data-cache fill path and external
//                memory bus seen by the cache controller.
//  Modports    : master - the controller (it masters the memory bus and the
//                         cache fill path, and stalls the CPU)
//                slave  - the surrounding CPU / data cache / memory
//  Signals     : cpu_read_en, cpu_write_en, cpu_addr, cpu_writedata,
//                cpu_byte_en, cache_hit, cache_rdata (cached word at
//                cpu_addr, used for the store merge), cpu_stall, fill_valid,
//                fill_addr, fill_data, mem_address, mem_read, mem_write,
//                mem_writedata, mem_byteenable, mem_waitrequest,
//                mem_readdata, err
//  Revision    : 1.0  initial release
// ============================================================================
interface mips_cache_controller_if;
   import mips_cache_pkg::*;

   logic              cpu_read_en;
   logic              cpu_write_en;
   logic [WORD_W-1:0] cpu_addr;
   logic [WORD_W-1:0] cpu_writedata;
   logic [BE_W-1:0]   cpu_byte_en;
   logic              cache_hit;
   logic [WORD_W-1:0] cache_rdata;
   logic              cpu_stall;

   logic              fill_valid;
   logic [WORD_W-1:0] fill_addr;
   logic [WORD_W-1:0] fill_data;

   logic [WORD_W-1:0] mem_address;
   logic              mem_read;
   logic              mem_write;
   logic [WORD_W-1:0] mem_writedata;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_waitrequest;
   logic [WORD_W-1:0] mem_readdata;

   logic              err;

   modport master (
      input  cpu_read_en, cpu_write_en, cpu_addr, cpu_writedata, cpu_byte_en,
             cache_hit, cache_rdata, mem_waitrequest, mem_readdata,
      output cpu_stall, fill_valid, fill_addr, fill_data, mem_address,
             mem_read, mem_write, mem_writedata, mem_byteenable, err
   );

   modport slave (
      output cpu_read_en, cpu_write_en, cpu_addr, cpu_writedata, cpu_byte_en,
             cache_hit, cache_rdata, mem_waitrequest, mem_readdata,
      input  cpu_stall, fill_valid, fill_addr, fill_data, mem_address,
             mem_read, mem_write, mem_writedata, mem_byteenable, err
   );

endinterface
`default_nettype wire

// File: rtl/mips_cache_controller_byte_merge.sv
`default_nettype none
// ============================================================================
//  Module      : mips_byte_merge
//  Description : Combinational byte-lane merge. Each byte of the result is
//                taken from new_word_i where its enable is set, otherwise
//                from old_word_i.
//  Ports       : old_word_i [32] existing word
//                new_word_i [32] store data
//                byte_en_i  [4]  lanes to take from new_word_i
//                merged_o   [32] merged word
//  Revision    : 1.0  initial release
// ============================================================================
module mips_byte_merge
   import mips_cache_pkg::*;
(
   input  logic [WORD_W-1:0] old_word_i,
   input  logic [WORD_W-1:0] new_word_i,
   input  logic [BE_W-1:0]   byte_en_i,
   output logic [WORD_W-1:0] merged_o
);

   for (genvar i = 0; i < BE_W; i++) begin : g_lane
      assign merged_o[8*i +: 8] = byte_en_i[i] ? new_word_i[8*i +: 8]
                                               : old_word_i[8*i +: 8];
   end

endmodule
`default_nettype wire

// File: rtl/mips_cache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cache_controller
//  Description : Data-cache controller for a MIPS core. Read misses fetch
//                one word from memory and fill the cache; stores are
//                write-through / no-write-allocate, and a store that hit
//                refreshes the cached word with the byte-merged data.
//                A sticky error flag records a memory access that waited
//                TIMEOUT cycles; that access is abandoned without a fill.
//  Ports       : clk   - clock, rising edge
//                rst_n - synchronous active-low reset
//                bus   - mips_cache_controller_if.master (CPU, cache fill,
//                        memory bus, err)
//  Parameters  : TIMEOUT - waitrequest cycles tolerated per access (>= 1)
//  Revision    : 1.0  initial release
// ============================================================================
module mips_cache_controller
   import mips_cache_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   mips_cache_controller_if.master bus
);

   localparam int               CNT_W      = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [WORD_W-1:0] addr_q;
   logic [WORD_W-1:0] wdata_q;
   logic [BE_W-1:0]   be_q;
   logic [WORD_W-1:0] old_q;
   logic              hit_q;
   logic [WORD_W-1:0] fill_data_q;
   logic              fill_valid_q;
   logic              mem_read_q;
   logic              mem_write_q;
   logic              err_q;

   logic [WORD_W-1:0] merged_word;
   logic              stall_req;

   mips_byte_merge u_merge (
      .old_word_i (old_q),
      .new_word_i (wdata_q),
      .byte_en_i  (be_q),
      .merged_o   (merged_word)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         old_q        <= '0;
         hit_q        <= 1'b0;
         fill_data_q  <= '0;
         fill_valid_q <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         fill_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               // Stores take priority; a read hit needs no controller action.
               if (bus.cpu_write_en) begin
                  addr_q      <= bus.cpu_addr;
                  wdata_q     <= bus.cpu_writedata;
                  be_q        <= bus.cpu_byte_en;
                  old_q       <= bus.cache_rdata;
                  hit_q       <= bus.cache_hit;
                  mem_write_q <= 1'b1;
                  state_q     <= ST_WR_REQ;
               end else if (bus.cpu_read_en && !bus.cache_hit) begin
                  addr_q     <= bus.cpu_addr;
                  hit_q      <= 1'b0;
                  mem_read_q <= 1'b1;
                  state_q    <= ST_RD_REQ;
               end
            end
            ST_RD_REQ: begin
               if (!bus.mem_waitrequest) begin
                  fill_data_q  <= bus.mem_readdata;
                  fill_valid_q <= 1'b1;
                  mem_read_q   <= 1'b0;
                  state_q      <= ST_RD_FILL;
               end else if (cnt_q == c_cnt_last) begin
                  err_q      <= 1'b1;
                  mem_read_q <= 1'b0;
                  state_q    <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_RD_FILL: begin
               state_q <= ST_DONE;
            end
            ST_WR_REQ: begin
               if (!bus.mem_waitrequest) begin
                  // Keep the cached copy coherent only when the store hit.
                  fill_data_q  <= merged_word;
                  fill_valid_q <= hit_q;
                  mem_write_q  <= 1'b0;
                  state_q      <= ST_DONE;
               end else if (cnt_q == c_cnt_last) begin
                  err_q       <= 1'b1;
                  mem_write_q <= 1'b0;
                  state_q     <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // The stall must rise in the very cycle a miss or store is presented,
   // so it is decoded from the live request while idle.
   always_comb begin
      stall_req = 1'b0;
      case (state_q)
         ST_IDLE:                         stall_req = bus.cpu_write_en |
                                                      (bus.cpu_read_en & ~bus.cache_hit);
         ST_RD_REQ, ST_RD_FILL, ST_WR_REQ: stall_req = 1'b1;
         default:                         stall_req = 1'b0;
      endcase
   end

   assign bus.cpu_stall      = rst_n & stall_req;
   assign bus.fill_valid     = fill_valid_q;
   assign bus.fill_addr      = addr_q;
   assign bus.fill_data      = fill_data_q;
   assign bus.mem_address    = addr_q;
   assign bus.mem_read       = mem_read_q;
   assign bus.mem_write      = mem_write_q;
   assign bus.mem_writedata  = wdata_q;
   assign bus.mem_byteenable = mem_read_q  ? {BE_W{1'b1}} :
                               mem_write_q ? be_q : '0;
   assign bus.err            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_cache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_cache_controller
//  Description : Self-checking bench for mips_cache_controller. A memory
//                responder drives waitrequest/readdata; each CPU access is
//                predicted by a transaction-level model (cycle counts, fill
//                contents, error flag) and compared after it completes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_cache_controller;
   import mips_cache_pkg::*;

   localparam int TB_TIMEOUT = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   model_err = 1'b0;

   mips_cache_controller_if bus();

   mips_cache_controller #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
      logic [31:0] mask;
      mask = '0;
      for (int i = 0; i < 4; i++)
         if (be[i]) mask = mask | (32'hFF << (8 * i));
      return (old_w & ~mask) | (new_w & mask);
   endfunction

   // One complete CPU access: drive it, service memory with w wait cycles,
   // then compare what was observed against the transaction model.
   task automatic run_txn(input string tag, input bit is_wr, input logic [31:0] addr,
                          input logic hit, input int w, input logic [31:0] rdata,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] old_w);
      int          exp_stall, exp_rd, exp_wr, exp_fill, exp_act;
      logic [31:0] exp_fdata;
      bit          timeout, done, bus_ok;
      int          stall_n, rd_n, wr_n, fill_n, act;
      logic [31:0] f_addr, f_data;

      // ---- model ----
      timeout = 1'b0; exp_stall = 0; exp_rd = 0; exp_wr = 0; exp_fill = 0;
      exp_act = 0; exp_fdata = '0;
      if (is_wr || !hit) begin
         timeout = (w >= TB_TIMEOUT);
         if (timeout) begin
            exp_act   = TB_TIMEOUT;
            exp_stall = 1 + TB_TIMEOUT;
         end else begin
            exp_act   = w + 1;
            exp_stall = w + (is_wr ? 2 : 3);
            exp_fill  = is_wr ? int'(hit) : 1;
         end
         if (is_wr) exp_wr = exp_act;
         else       exp_rd = exp_act;
         exp_fdata = is_wr ? ref_merge(old_w, wdata, be) : rdata;
      end

      // ---- stimulus / observation ----
      stall_n = 0; rd_n = 0; wr_n = 0; fill_n = 0; act = 0;
      f_addr = '0; f_data = '0; done = 1'b0; bus_ok = 1'b1;
      bus.cpu_addr      = addr;
      bus.cpu_writedata = wdata;
      bus.cpu_byte_en   = be;
      bus.cache_hit     = hit;
      bus.cache_rdata   = old_w;
      bus.cpu_read_en   = !is_wr;
      bus.cpu_write_en  = is_wr;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         if (cyc > 0) begin
            // The access is latched; further operand changes must not matter.
            bus.cpu_addr      = $urandom() & 32'hFFFF_FFFC;
            bus.cpu_writedata = $urandom();
            bus.cpu_byte_en   = 4'($urandom());
            bus.cache_rdata   = $urandom();
            bus.cache_hit     = 1'($urandom());
         end
         if (bus.mem_read || bus.mem_write) begin
            bus.mem_waitrequest = (act < w);
            bus.mem_readdata    = (act < w) ? $urandom() : rdata;
            act++;
         end else begin
            bus.mem_waitrequest = 1'b1;
            bus.mem_readdata    = $urandom();
         end
         #4;
         if (bus.cpu_stall) stall_n++;
         else               done = 1'b1;
         if (bus.mem_read)  rd_n++;
         if (bus.mem_write) wr_n++;
         if (bus.mem_read || bus.mem_write) begin
            if (bus.mem_address !== addr)                       bus_ok = 1'b0;
            if (bus.mem_read && bus.mem_write)                  bus_ok = 1'b0;
            if (bus.mem_read && bus.mem_byteenable !== 4'hF)    bus_ok = 1'b0;
            if (bus.mem_write && (bus.mem_byteenable !== be ||
                                  bus.mem_writedata !== wdata)) bus_ok = 1'b0;
         end
         if (bus.fill_valid) begin
            fill_n++;
            f_addr = bus.fill_addr;
            f_data = bus.fill_data;
         end
         @(posedge clk); #1;
      end
      bus.cpu_read_en  = 1'b0;
      bus.cpu_write_en = 1'b0;
      if (timeout) model_err = 1'b1;

      check({tag, "_done"},  32'(done),    32'd1);
      check({tag, "_stall"}, stall_n,      exp_stall);
      check({tag, "_rd"},    rd_n,         exp_rd);
      check({tag, "_wr"},    wr_n,         exp_wr);
      check({tag, "_fill"},  fill_n,       exp_fill);
      check({tag, "_bus"},   32'(bus_ok),  32'd1);
      check({tag, "_err"},   32'(bus.err), 32'(model_err));
      if (exp_fill != 0) begin
         check({tag, "_faddr"}, f_addr, addr);
         check({tag, "_fdata"}, f_data, exp_fdata);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]  kind;
      logic [31:0] a;
      int          fills, reads;

      // ---- reset: outputs quiet even with a store presented ----
      bus.cpu_read_en = 1'b0; bus.cpu_write_en = 1'b1; bus.cpu_addr = 32'h44;
      bus.cpu_writedata = 32'hFFFF_FFFF; bus.cpu_byte_en = 4'hF; bus.cache_hit = 1'b1;
      bus.cache_rdata = '0; bus.mem_waitrequest = 1'b0; bus.mem_readdata = 32'h1234_5678;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", 32'(bus.cpu_stall),  32'd0);
      check("rst_fill",  32'(bus.fill_valid), 32'd0);
      check("rst_mrd",   32'(bus.mem_read),   32'd0);
      check("rst_mwr",   32'(bus.mem_write),  32'd0);
      check("rst_err",   32'(bus.err),        32'd0);
      check("rst_addr",  bus.mem_address,     32'd0);
      check("rst_fdata", bus.fill_data,       32'd0);
      bus.cpu_write_en = 1'b0;
      rst_n = 1'b1;
      #4;
      check("post_rst_outs", {bus.cpu_stall, bus.fill_valid, bus.mem_read, bus.mem_write,
                              bus.err, bus.mem_byteenable}, 32'd0);
      @(posedge clk); #1;

      // ---- directed accesses ----
      run_txn("rd_hit",  1'b0, 32'h100, 1'b1, 0, 32'h0,         32'h0,         4'h0,    32'h0);
      run_txn("rd_miss", 1'b0, 32'h200, 1'b0, 2, 32'hDEADBEEF,  32'h0,         4'h0,    32'h0);
      run_txn("wr_hit",  1'b1, 32'h104, 1'b1, 1, 32'h0,         32'h0000ABCD,  4'b0011, 32'h12345678);
      run_txn("wr_miss", 1'b1, 32'h300, 1'b0, 0, 32'h0,         32'hCAFEF00D,  4'hF,    32'h0);

      // ---- randomized accesses, wait states below the timeout ----
      for (int k = 0; k < 16; k++) begin
         kind = 2'($urandom_range(0, 3));
         a    = $urandom() & 32'hFFFF_FFFC;
         run_txn("rand", kind[1], a, kind[0], $urandom_range(0, TB_TIMEOUT - 1),
                 $urandom(), $urandom(), 4'($urandom()), $urandom());
      end

      // ---- memory timeout, then err stays set across a normal access ----
      run_txn("tmo_rd", 1'b0, 32'h500, 1'b0, 50, 32'h11111111, 32'h0, 4'h0, 32'h0);
      run_txn("tmo_wr", 1'b1, 32'h504, 1'b1, 50, 32'h0, 32'h55AA55AA, 4'b1010, 32'h0F0F0F0F);
      run_txn("sticky", 1'b0, 32'h600, 1'b1, 0, 32'h0, 32'h0, 4'h0, 32'h0);

      // ---- reset in the middle of a read request ----
      bus.cpu_addr = 32'h400; bus.cache_hit = 1'b0; bus.cpu_read_en = 1'b1;
      bus.mem_waitrequest = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_pre_rd", 32'(bus.mem_read), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      model_err = 1'b0;
      check("mid_rd",    32'(bus.mem_read),   32'd0);
      check("mid_stall", 32'(bus.cpu_stall),  32'd0);
      check("mid_fill",  32'(bus.fill_valid), 32'd0);
      check("mid_err",   32'(bus.err),        32'(model_err));
      rst_n = 1'b1;
      bus.cpu_read_en = 1'b0;
      bus.mem_waitrequest = 1'b0;
      fills = 0; reads = 0;
      for (int c = 0; c < 6; c++) begin
         #4;
         if (bus.fill_valid) fills++;
         if (bus.mem_read)   reads++;
         @(posedge clk); #1;
      end
      check("after_rst_fill", fills, 0);
      check("after_rst_rd",   reads, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
